process_scheduler: RTL and testbench
====================================

PROCESS_SCHEDULER -- requirements
Module: process_scheduler

Interface
REQ-001 Parameter NPROC, default 8, number of process slots; SHALL be a power of two, 2..16.
REQ-002 Parameter PID_W, default 3, process-id width, equal to log2(NPROC).
REQ-003 Parameter PC_W, default 32, saved program-counter width.
REQ-004 Clock  in  1  system clock; all state changes on its rising edge.
REQ-005 Reset  in  1  synchronous, active-high.
REQ-006 quantum_end  in  1  single-cycle pulse from the quantum timer: time slice expired.
REQ-007 halt  in  1  the running process executed halt; level, sampled only in RUN.
REQ-008 io_wait  in  1  the running process is blocked on input; freezes the time slice.
REQ-009 cur_pc  in  PC_W  PC of the running process, captured on save.
REQ-010 create_valid  in  1  request to load a new process.
REQ-011 create_pid  in  PID_W  slot to load.
REQ-012 create_pc  in  PC_W  start PC of the new process.
REQ-013 create_ack  out  1  one-cycle pulse: create accepted.
REQ-014 create_err  out  1  one-cycle pulse: create rejected because the slot is occupied.
REQ-015 quantum_enable  out  1  timer count enable (drives the timer's Quantum_flag).
REQ-016 timer_clear  out  1  one-cycle pulse that restarts the timer count.
REQ-017 pc_load  out  1  one-cycle pulse: the processor loads next_pc into its PC.
REQ-018 next_pc  out  PC_W  PC of the selected process; valid while pc_load=1.
REQ-019 cur_pid  out  PID_W  id of the running or last-run process.
REQ-020 idle  out  1  high while no process is ready.

Function
REQ-021 The block SHALL hold a ready bit per slot and a PC table of NPROC x PC_W.
REQ-022 The state machine SHALL have exactly five states: IDLE, RUN, SAVE, SELECT, RESTORE.
REQ-023 IDLE: idle=1, quantum_enable=0; any ready bit set -> SELECT next cycle.
REQ-024 RUN: quantum_enable=!io_wait.
- halt=1 -> clear ready[cur_pid], go to SELECT; no save.
- else quantum_end=1 -> SAVE.
- halt has priority over quantum_end in the same cycle.
REQ-025 SAVE: write cur_pc to pc_table[cur_pid]; ready stays set; -> SELECT. One cycle.
REQ-026 SELECT: round-robin search for a ready slot, starting at cur_pid+1 modulo NPROC and wrapping.
- Hit -> latch the slot as the new cur_pid and go to RESTORE.
- No hit -> IDLE.
- The search SHALL complete in one cycle.
- The current slot is chosen only if it is the sole ready slot.
REQ-027 RESTORE: pc_load=1, next_pc=pc_table[cur_pid], timer_clear=1; -> RUN. One cycle.
REQ-028 quantum_enable SHALL be 0 in every state other than RUN.
REQ-029 Context-switch latency SHALL be fixed:
- quantum_end in RUN at cycle t -> SAVE at t+1, SELECT at t+2, pc_load at t+3, RUN at t+4.
- halt at cycle t -> pc_load at t+2.
REQ-030 quantum_end SHALL be ignored outside RUN.
REQ-031 Create handling, accepted in any state, decided in the request cycle, response registered one cycle later:
- ready[create_pid]=0 -> set the ready bit, write create_pc to pc_table[create_pid], pulse create_ack.
- ready[create_pid]=1 -> pulse create_err; ready bits and PC table unchanged.
REQ-032 A create that collides with a halt of the same pid in the same cycle SHALL win: the ready bit ends set and the PC table holds create_pc.
REQ-033 A create of a slot that is ready during SELECT SHALL be visible to that SELECT.
- The pc_table write SHALL be visible to a RESTORE of that slot in the following cycle.
REQ-034 create_ack and create_err SHALL never be high together.

Reset
REQ-035 On Reset=1 at a clock edge, regardless of state:
- state=IDLE, all ready bits=0, cur_pid=0, all PC table entries=0.
- create_ack=0, create_err=0, quantum_enable=0, timer_clear=0, pc_load=0, next_pc=0.
- idle=1 from the next cycle.
REQ-036 Reset SHALL override all other inputs in the same cycle, including a pending create, which SHALL be dropped.

Verification
REQ-037 Create pid2 pc=0x100 from IDLE -> create_ack; SELECT; pc_load with next_pc=0x100; cur_pid=2; quantum_enable=1.
REQ-038 Pids 0,1,3 ready, running 3, cur_pc=0x3C, quantum_end -> pc_table[3]=0x3C; wrap to pid0; pc_load exactly 3 cycles after quantum_end.
REQ-039 halt and quantum_end together in RUN with only pid1 ready -> ready[1]=0, no save, SELECT finds nothing, IDLE, idle=1, quantum_enable=0.
REQ-040 Create pid5 while pid5 is ready -> create_err for 1 cycle; pc_table[5] unchanged; no create_ack.
REQ-041 io_wait=1 in RUN -> quantum_enable=0 for the whole interval; quantum_end never asserted; resumes to 1 the cycle after io_wait drops.
REQ-042 Reset asserted in RESTORE -> no pc_load the next cycle; every output at its reset value; all ready bits clear.

Source files
------------

// File: rtl/process_scheduler.sv
// Round-robin process scheduler: tracks ready slots and saved PCs, and sequences
// the save/select/restore context switch around quantum expiry and halt.
module process_scheduler #(
  parameter int NPROC = 8,
  parameter int PID_W = 3,
  parameter int PC_W  = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             quantum_end,
  input  logic             halt,
  input  logic             io_wait,
  input  logic [PC_W-1:0]  cur_pc,
  input  logic             create_valid,
  input  logic [PID_W-1:0] create_pid,
  input  logic [PC_W-1:0]  create_pc,
  output logic             create_ack,
  output logic             create_err,
  output logic             quantum_enable,
  output logic             timer_clear,
  output logic             pc_load,
  output logic [PC_W-1:0]  next_pc,
  output logic [PID_W-1:0] cur_pid,
  output logic             idle
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    SAVE    = 3'd2,
    SELECT  = 3'd3,
    RESTORE = 3'd4
  } state_e;

  state_e                       state_q, state_d;
  logic [NPROC-1:0]             ready_q, ready_d;
  logic [PID_W-1:0]             cur_pid_q, cur_pid_d;
  logic [NPROC-1:0][PC_W-1:0]   pc_table_q, pc_table_d;
  logic                         create_ack_q, create_ack_d;
  logic                         create_err_q, create_err_d;

  logic                         halt_clr;
  logic                         slot_busy;
  logic                         found;
  logic [PID_W-1:0]             sel_pid;
  logic [PID_W-1:0]             idx;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned; an unassigned path would infer a latch.
  always_comb begin
    state_d      = state_q;
    ready_d      = ready_q;
    cur_pid_d    = cur_pid_q;
    pc_table_d   = pc_table_q;
    create_ack_d = 1'b0;
    create_err_d = 1'b0;

    halt_clr  = (state_q == RUN) && halt;
    // A create racing a halt of the same slot sees the slot as already freed.
    slot_busy = ready_q[create_pid] && !(halt_clr && (create_pid == cur_pid_q));

    if (halt_clr) ready_d[cur_pid_q] = 1'b0;
    if (state_q == SAVE) pc_table_d[cur_pid_q] = cur_pc;

    if (create_valid) begin
      if (slot_busy) begin
        create_err_d = 1'b1;
      end else begin
        ready_d[create_pid]    = 1'b1;
        pc_table_d[create_pid] = create_pc;
        create_ack_d           = 1'b1;
      end
    end

    // Search starts after the current slot; i == NPROC wraps back onto it last.
    // ready_d includes a same-cycle create, so SELECT sees it immediately.
    found   = 1'b0;
    sel_pid = cur_pid_q;
    idx     = cur_pid_q;
    for (int i = 1; i <= NPROC; i++) begin
      idx = cur_pid_q + PID_W'(i);
      if (!found && ready_d[idx]) begin
        found   = 1'b1;
        sel_pid = idx;
      end
    end

    unique case (state_q)
      IDLE:    if (|ready_q) state_d = SELECT;
      RUN: begin
        if (halt)             state_d = SELECT;
        else if (quantum_end) state_d = SAVE;
      end
      SAVE:    state_d = SELECT;
      SELECT: begin
        if (found) begin
          cur_pid_d = sel_pid;
          state_d   = RESTORE;
        end else begin
          state_d   = IDLE;
        end
      end
      RESTORE: state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= IDLE;
      ready_q      <= '0;
      cur_pid_q    <= '0;
      // NOTE: the PC table is flop-based and explicitly cleared on reset, so a
      // restore can never present stale contents from before reset.
      pc_table_q   <= '0;
      create_ack_q <= 1'b0;
      create_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      cur_pid_q    <= cur_pid_d;
      pc_table_q   <= pc_table_d;
      create_ack_q <= create_ack_d;
      create_err_q <= create_err_d;
    end
  end

  assign create_ack     = create_ack_q;
  assign create_err     = create_err_q;
  assign quantum_enable = (state_q == RUN) && !io_wait;
  assign pc_load        = (state_q == RESTORE);
  assign timer_clear    = (state_q == RESTORE);
  assign next_pc        = pc_load ? pc_table_q[cur_pid_q] : '0;
  assign cur_pid        = cur_pid_q;
  assign idle           = (state_q == IDLE);

endmodule

// File: tb/tb_process_scheduler.sv
// Directed bench for process_scheduler: creates, context switches, halt, io_wait,
// create collisions and reset, each checked against hand-derived values.
module tb_process_scheduler;

  localparam int NPROC = 8;
  localparam int PID_W = 3;
  localparam int PC_W  = 32;

  logic             Clock = 1'b0;
  logic             Reset;
  logic             quantum_end, halt, io_wait, create_valid;
  logic [PC_W-1:0]  cur_pc, create_pc;
  logic [PID_W-1:0] create_pid;
  logic             create_ack, create_err, quantum_enable, timer_clear, pc_load, idle;
  logic [PC_W-1:0]  next_pc;
  logic [PID_W-1:0] cur_pid;

  int n_cmp  = 0;
  int n_fail = 0;

  process_scheduler #(.NPROC(NPROC), .PID_W(PID_W), .PC_W(PC_W)) dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .quantum_end    (quantum_end),
    .halt           (halt),
    .io_wait        (io_wait),
    .cur_pc         (cur_pc),
    .create_valid   (create_valid),
    .create_pid     (create_pid),
    .create_pc      (create_pc),
    .create_ack     (create_ack),
    .create_err     (create_err),
    .quantum_enable (quantum_enable),
    .timer_clear    (timer_clear),
    .pc_load        (pc_load),
    .next_pc        (next_pc),
    .cur_pid        (cur_pid),
    .idle           (idle)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle 1 time unit after it, away from the edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic create(input logic [PID_W-1:0] pid, input logic [PC_W-1:0] pc);
    create_valid = 1'b1;
    create_pid   = pid;
    create_pc    = pc;
  endtask

  task automatic restore_check(input string tag, input int pid, input logic [31:0] pc);
    check({tag, " pc_load"},     32'(pc_load),     32'd1);
    check({tag, " timer_clear"}, 32'(timer_clear), 32'd1);
    check({tag, " next_pc"},     next_pc,          pc);
    check({tag, " cur_pid"},     32'(cur_pid),     32'(pid));
    check({tag, " qen"},         32'(quantum_enable), 32'd0);
  endtask

  initial begin
    Reset = 1'b1; quantum_end = 1'b0; halt = 1'b0; io_wait = 1'b0;
    cur_pc = '0; create_valid = 1'b0; create_pid = '0; create_pc = '0;

    // Reset with a pending create: the create must be dropped.
    create(3'd4, 32'h444);
    tick();
    Reset = 1'b0; create_valid = 1'b0;
    check("rst idle",    32'(idle),           32'd1);
    check("rst pc_load", 32'(pc_load),        32'd0);
    check("rst next_pc", next_pc,             32'd0);
    check("rst qen",     32'(quantum_enable), 32'd0);
    check("rst ack",     32'(create_ack),     32'd0);
    check("rst err",     32'(create_err),     32'd0);
    check("rst cur_pid", 32'(cur_pid),        32'd0);
    tick(); tick();
    check("rst create dropped", 32'(idle), 32'd1);

    // First process from IDLE.
    create(3'd2, 32'h100);
    tick(); create_valid = 1'b0;
    check("c2 ack",  32'(create_ack), 32'd1);
    check("c2 err",  32'(create_err), 32'd0);
    check("c2 idle", 32'(idle),       32'd1);
    tick();
    check("c2 select idle", 32'(idle),       32'd0);
    check("c2 ack pulse",   32'(create_ack), 32'd0);
    tick();
    restore_check("r2", 2, 32'h100);
    tick();
    check("run2 pc_load", 32'(pc_load),        32'd0);
    check("run2 qen",     32'(quantum_enable), 32'd1);

    // io_wait freezes the time slice only while high.
    io_wait = 1'b1; #1;
    check("io qen0", 32'(quantum_enable), 32'd0);
    tick();
    check("io qen0 held", 32'(quantum_enable), 32'd0);
    check("io still run", 32'(pc_load),        32'd0);
    io_wait = 1'b0; #1;
    check("io qen1", 32'(quantum_enable), 32'd1);

    // Load pids 0,1,3 while pid 2 runs, then halt 2: next is 3.
    create(3'd0, 32'h200); tick();
    create(3'd1, 32'h210); tick();
    create(3'd3, 32'h300); tick(); create_valid = 1'b0;
    check("c3 ack", 32'(create_ack), 32'd1);
    halt = 1'b1; tick(); halt = 1'b0;
    check("h2 select no load", 32'(pc_load), 32'd0);
    tick();
    restore_check("r3", 3, 32'h300);
    tick();

    // Quantum expiry on pid 3: save 0x3C, wrap to pid 0, pc_load 3 cycles later.
    cur_pc = 32'h3C; quantum_end = 1'b1; tick(); quantum_end = 1'b0;
    check("q3 save no load", 32'(pc_load),        32'd0);
    check("q3 save qen",     32'(quantum_enable), 32'd0);
    quantum_end = 1'b1; tick(); quantum_end = 1'b0;
    check("q3 select no load", 32'(pc_load), 32'd0);
    tick();
    restore_check("r0 wrap", 0, 32'h200);
    tick();

    // Create of an occupied slot: error pulse, table untouched.
    create(3'd3, 32'hBAD); tick(); create_valid = 1'b0;
    check("c3dup err", 32'(create_err), 32'd1);
    check("c3dup ack", 32'(create_ack), 32'd0);
    cur_pc = 32'h44; quantum_end = 1'b1; tick(); quantum_end = 1'b0;
    check("c3dup err pulse", 32'(create_err), 32'd0);
    tick(); tick();
    restore_check("r1", 1, 32'h210);
    tick();
    cur_pc = 32'h55; quantum_end = 1'b1; tick(); quantum_end = 1'b0;
    tick(); tick();
    restore_check("r3 saved", 3, 32'h3C);
    tick();

    // Halt 3, then halt 0: pids 0 and 1 resume from their saved PCs.
    halt = 1'b1; tick(); halt = 1'b0; tick();
    restore_check("r0 saved", 0, 32'h44);
    tick();
    halt = 1'b1; tick(); halt = 1'b0; tick();
    restore_check("r1 saved", 1, 32'h55);
    tick();

    // halt and quantum_end together with pid 1 the sole ready slot.
    cur_pc = 32'h99; halt = 1'b1; quantum_end = 1'b1; tick();
    halt = 1'b0; quantum_end = 1'b0;
    check("hq select no load", 32'(pc_load), 32'd0);
    check("hq select idle",    32'(idle),    32'd0);
    tick();
    check("hq idle", 32'(idle),           32'd1);
    check("hq qen",  32'(quantum_enable), 32'd0);
    tick();
    check("hq idle held", 32'(idle),    32'd1);
    check("hq last pid",  32'(cur_pid), 32'd1);

    // Current slot chosen when it is the only one ready.
    create(3'd1, 32'h700); tick(); create_valid = 1'b0;
    check("c1 ack", 32'(create_ack), 32'd1);
    tick(); tick();
    restore_check("r1 self", 1, 32'h700);
    tick();

    // Create colliding with a halt of the same pid wins.
    halt = 1'b1; create(3'd1, 32'h800); tick();
    halt = 1'b0; create_valid = 1'b0;
    check("hc ack", 32'(create_ack), 32'd1);
    check("hc err", 32'(create_err), 32'd0);
    tick();
    restore_check("r1 hc", 1, 32'h800);
    tick();

    // Create during SELECT is visible to that SELECT and its RESTORE.
    halt = 1'b1; tick(); halt = 1'b0;
    create(3'd6, 32'h600); tick(); create_valid = 1'b0;
    restore_check("r6 bypass", 6, 32'h600);
    check("r6 ack", 32'(create_ack), 32'd1);

    // Reset in RESTORE.
    Reset = 1'b1; tick(); Reset = 1'b0;
    check("rr pc_load", 32'(pc_load),        32'd0);
    check("rr tclr",    32'(timer_clear),    32'd0);
    check("rr next_pc", next_pc,             32'd0);
    check("rr ack",     32'(create_ack),     32'd0);
    check("rr qen",     32'(quantum_enable), 32'd0);
    check("rr cur_pid", 32'(cur_pid),        32'd0);
    check("rr idle",    32'(idle),           32'd1);
    tick(); tick();
    check("rr ready clear", 32'(idle), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
